alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller in front of the combinational ALU (cntrl encoding 0–11).
- Accepts one operation request at a time over a valid/ready handshake and registers the operands.
- Drives the ALU for a per-class number of settle cycles (so the long mul/div paths do not set Fmax), then captures C_LO/C_HI into response registers.
- Presents the result on a valid/ready response port; flags illegal opcodes and divide-by-zero without exercising the ALU.

Parameters:
- ALU_CYCLES, 1, EXEC cycles for ops 0–9; range 1–255
- MUL_CYCLES, 4, EXEC cycles for op 10 (booth multiply); range 1–255
- DIV_CYCLES, 8, EXEC cycles for op 11 (divide); range 1–255

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_op  in  4  ALU opcode (0 AND, 1 OR, 2 ADD, 3 SUB, 4 NEG, 5 NOT, 6 SHL, 7 SHR, 8 ROL, 9 ROR, 10 MUL, 11 DIV)
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_cntrl  out  4  registered opcode to ALU
- alu_c_lo  in  32  ALU C_LO
- alu_c_hi  in  32  ALU C_HI
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  consumer accepts response
- rsp_lo  out  32  result low word (LO / Z)
- rsp_hi  out  32  result high word (HI)
- rsp_err  out  1  1 = illegal opcode or divide-by-zero
- busy  out  1  state != IDLE

Behaviour:

Reset:
- clear low at any time, including mid-operation, forces IDLE asynchronously.
- alu_a, alu_b, alu_cntrl, rsp_lo, rsp_hi = 0; rsp_valid, rsp_err, busy = 0; wait counter = 0.
- An in-flight operation is discarded; no response is produced.

States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE) | (state==DONE & rsp_ready).
- Accept = req_valid & req_ready, evaluated at the rising edge.

On accept:
- Latch req_a/req_b/req_op into alu_a/alu_b/alu_cntrl.
- req_op 12–15 -> DONE next edge; rsp_err=1, rsp_lo=rsp_hi=0; ALU result ignored.
- req_op 11 with req_b==0 -> DONE next edge; rsp_err=1, rsp_lo=32'hFFFFFFFF, rsp_hi=req_a.
- Otherwise -> EXEC; counter = N-1, where N = ALU_CYCLES / MUL_CYCLES / DIV_CYCLES by op class.

EXEC:
- Operands and cntrl held stable.
- Counter decrements each edge.
- At the edge where counter==0: capture rsp_lo=alu_c_lo, rsp_err=0, and go to DONE.
- rsp_hi = alu_c_hi for ops 10/11; rsp_hi = 0 for ops 0–9, because the ALU does not drive C_HI for those ops.

Latency:
- rsp_valid rises exactly N edges after the accept edge (ALU_CYCLES=1: first edge after accept).
- Error responses: 1 edge after accept.

DONE:
- rsp_valid=1; rsp_lo/rsp_hi/rsp_err held until rsp_valid & rsp_ready.
- On that handshake with no new accept -> IDLE; rsp_valid=0; rsp_* retain last values.
- Simultaneous response handshake and new request accept in the same cycle: the response retires and the new request is latched on the same edge (back-to-back, no bubble).

Other rules:
- req_valid while busy and not req_ready: request ignored; the requester must hold it.
- alu_a/alu_b/alu_cntrl change only on accept and are otherwise held, including in IDLE.
- Counter is 8 bits.
- Parameter values of 0 are illegal; the implementation asserts on them in simulation.

Test Plan:
1. Reset mid-EXEC: start MUL, pull clear low during EXEC cycle 2 -> all outputs 0 immediately, state IDLE, no rsp_valid after release.
2. ADD: A=5, B=7, op 2 -> rsp_valid 1 edge after accept, rsp_lo=12, rsp_hi=0, rsp_err=0; alu_cntrl=2 held through DONE.
3. MUL with MUL_CYCLES=4: A=32'h0001_0000, B=32'h0001_0000, op 10 -> rsp_valid exactly 4 edges after accept, rsp_hi=1, rsp_lo=0; req_ready=0 throughout EXEC.
4. DIV by zero: A=100, B=0, op 11 -> DONE after 1 edge, rsp_err=1, rsp_lo=32'hFFFFFFFF, rsp_hi=100. Illegal op 13 -> rsp_err=1, rsp_lo=rsp_hi=0.
5. Back-pressure and back-to-back:
   - Hold rsp_ready=0 for 5 cycles after an SUB result (9-4=5) -> rsp_lo stays 5, req_ready=0.
   - Then assert rsp_ready with req_valid (op 0, A=F0, B=3C) -> same-edge retire + accept; next response rsp_lo=32'h30.
6. DIV with DIV_CYCLES=8: A=17, B=5 -> rsp_valid 8 edges after accept, rsp_lo/rsp_hi equal ALU C_LO/C_HI sampled at the final EXEC edge (quotient 3, remainder 2 per divider packing); busy=1 from accept edge until handshake.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of the combinational ALU.
// Registers operands, waits per-class settle cycles, holds the response.
module alu_op_sequencer #(
   parameter int ALU_CYCLES = 1,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_cntrl,
   input  logic [31:0] alu_c_lo,
   input  logic [31:0] alu_c_hi,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_lo,
   output logic [31:0] rsp_hi,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_OP, ERR_DIV0} err_t;

   localparam logic [7:0] ALU_N = 8'(ALU_CYCLES - 1);
   localparam logic [7:0] MUL_N = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_N = 8'(DIV_CYCLES - 1);

   state_t     state;
   err_t       pend;
   logic [7:0] cnt;
   logic       accept;
   logic       wide_op;
   err_t       load_err;
   logic [7:0] load_cnt;

   assign req_ready = (state == IDLE) | ((state == DONE) & rsp_ready);
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign wide_op   = (alu_cntrl == 4'd10) | (alu_cntrl == 4'd11);

   // Error requests still pass through one EXEC edge so every
   // response shares the same minimum one-edge latency.
   always_comb begin
      load_err = ERR_NONE;
      load_cnt = ALU_N;
      unique case (1'b1)
         (req_op >= 4'd12): begin
            load_err = ERR_OP;
            load_cnt = '0;
         end
         (req_op == 4'd11) && (req_b == '0): begin
            load_err = ERR_DIV0;
            load_cnt = '0;
         end
         (req_op == 4'd11) && (req_b != '0): load_cnt = DIV_N;
         (req_op == 4'd10): load_cnt = MUL_N;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= IDLE;
         pend      <= ERR_NONE;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cntrl <= '0;
         rsp_lo    <= '0;
         rsp_hi    <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         alu_a     <= req_a;
         alu_b     <= req_b;
         alu_cntrl <= req_op;
         pend      <= load_err;
         cnt       <= load_cnt;
         state     <= EXEC;
      end else begin
         unique case (state)
            EXEC: begin
               if (cnt == '0) begin
                  state <= DONE;
                  unique case (pend)
                     ERR_OP: begin
                        rsp_lo  <= '0;
                        rsp_hi  <= '0;
                        rsp_err <= 1'b1;
                     end
                     ERR_DIV0: begin
                        rsp_lo  <= '1;
                        rsp_hi  <= alu_a;
                        rsp_err <= 1'b1;
                     end
                     default: begin
                        rsp_lo  <= alu_c_lo;
                        rsp_hi  <= wide_op ? alu_c_hi : '0;
                        rsp_err <= 1'b0;
                     end
                  endcase
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: if (rsp_ready) state <= IDLE;
            default: ;
         endcase
      end
   end

   param_legal: assert property (@(posedge clock)
      ALU_CYCLES >= 1 && ALU_CYCLES <= 255 &&
      MUL_CYCLES >= 1 && MUL_CYCLES <= 255 &&
      DIV_CYCLES >= 1 && DIV_CYCLES <= 255);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model.
// Vector table plus hand sequences for reset, back-pressure, back-to-back.
module tb_alu_op_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_cntrl;
   logic [31:0] alu_c_lo, alu_c_hi;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_lo, rsp_hi;
   logic        rsp_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   alu_op_sequencer #(
      .ALU_CYCLES(1), .MUL_CYCLES(4), .DIV_CYCLES(8)
   ) dut (
      .clock(clock), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
      .alu_c_lo(alu_c_lo), .alu_c_hi(alu_c_hi),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
      .busy(busy)
   );

   // External ALU model; C_HI is junk for ops that do not drive it.
   always_comb begin
      logic [63:0] p;
      logic [4:0]  s;
      p = {32'd0, alu_a} * {32'd0, alu_b};
      s = alu_b[4:0];
      alu_c_lo = 32'hBAD0_BAD0;
      alu_c_hi = 32'hDEAD_BEEF;
      case (alu_cntrl)
         4'd0:  alu_c_lo = alu_a & alu_b;
         4'd1:  alu_c_lo = alu_a | alu_b;
         4'd2:  alu_c_lo = alu_a + alu_b;
         4'd3:  alu_c_lo = alu_a - alu_b;
         4'd4:  alu_c_lo = -alu_a;
         4'd5:  alu_c_lo = ~alu_a;
         4'd6:  alu_c_lo = alu_a << s;
         4'd7:  alu_c_lo = alu_a >> s;
         4'd8:  alu_c_lo = (alu_a << s) | (alu_a >> (6'd32 - {1'b0, s}));
         4'd9:  alu_c_lo = (alu_a >> s) | (alu_a << (6'd32 - {1'b0, s}));
         4'd10: begin
            alu_c_lo = p[31:0];
            alu_c_hi = p[63:32];
         end
         4'd11: if (alu_b != 0) begin
            alu_c_lo = alu_a / alu_b;
            alu_c_hi = alu_a % alu_b;
         end
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Present a request, accept on the next edge, return after it.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clock);
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      #1;
      chk("req_ready_before_accept", req_ready, 1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   // Count edges until rsp_valid; expects to start #1 after accept.
   task automatic wait_rsp(output int lat);
      lat = 0;
      chk("busy_after_accept", busy, 1);
      chk("no_valid_on_accept", rsp_valid, 0);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         chk("busy_in_flight", busy, 1);
         if (rsp_valid) begin
            lat = i;
            break;
         end
         chk("req_ready_in_exec", req_ready, 0);
      end
      if (lat == 0) chk("rsp_timeout", 0, 1);
   endtask

   task automatic retire();
      @(negedge clock);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      chk("valid_after_retire", rsp_valid, 0);
      chk("busy_after_retire", busy, 0);
   endtask

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int lat;
      logic seen;

      vecs[0]  = '{"add", 4'd2, 32'd5, 32'd7, 32'd12, 0, 0, 1};
      vecs[1]  = '{"sub", 4'd3, 32'd9, 32'd4, 32'd5, 0, 0, 1};
      vecs[2]  = '{"and", 4'd0, 32'hF0, 32'h3C, 32'h30, 0, 0, 1};
      vecs[3]  = '{"or", 4'd1, 32'hF0, 32'h0F, 32'hFF, 0, 0, 1};
      vecs[4]  = '{"neg", 4'd4, 32'd5, 32'd0, 32'hFFFF_FFFB, 0, 0, 1};
      vecs[5]  = '{"not", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 1};
      vecs[6]  = '{"shl", 4'd6, 32'd1, 32'd4, 32'd16, 0, 0, 1};
      vecs[7]  = '{"shr", 4'd7, 32'h80, 32'd3, 32'h10, 0, 0, 1};
      vecs[8]  = '{"rol", 4'd8, 32'h8000_0001, 32'd1, 32'd3, 0, 0, 1};
      vecs[9]  = '{"ror", 4'd9, 32'd1, 32'd1, 32'h8000_0000, 0, 0, 1};
      vecs[10] = '{"mul", 4'd10, 32'h1_0000, 32'h1_0000, 32'd0, 32'd1, 0, 4};
      vecs[11] = '{"div", 4'd11, 32'd17, 32'd5, 32'd3, 32'd2, 0, 8};
      vecs[12] = '{"div0", 4'd11, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1, 1};
      vecs[13] = '{"ill13", 4'd13, 32'd7, 32'd9, 32'd0, 32'd0, 1, 1};
      vecs[14] = '{"ill15", 4'd15, 32'd1, 32'd1, 32'd0, 32'd0, 1, 1};

      #1 clear = 1'b0;
      #1;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_cntrl", alu_cntrl, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_lo", rsp_lo, 0);
      chk("rst_req_ready", req_ready, 1);
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear = 1'b1;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_rsp(lat);
         chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         chk({vecs[i].name, "_lo"}, rsp_lo, vecs[i].lo);
         chk({vecs[i].name, "_hi"}, rsp_hi, vecs[i].hi);
         chk({vecs[i].name, "_err"}, rsp_err, vecs[i].err);
         chk({vecs[i].name, "_cntrl"}, alu_cntrl, vecs[i].op);
         chk({vecs[i].name, "_alu_a"}, alu_a, vecs[i].a);
         retire();
         chk({vecs[i].name, "_lo_kept"}, rsp_lo, vecs[i].lo);
         chk({vecs[i].name, "_cntrl_idle"}, alu_cntrl, vecs[i].op);
      end

      // Reset during the second EXEC cycle of a multiply.
      issue(4'd10, 32'd3, 32'd4);
      @(posedge clock);
      #3 clear = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_alu_a", alu_a, 0);
      chk("midrst_alu_b", alu_b, 0);
      chk("midrst_cntrl", alu_cntrl, 0);
      chk("midrst_rsp_lo", rsp_lo, 0);
      chk("midrst_rsp_err", rsp_err, 0);
      chk("midrst_req_ready", req_ready, 1);
      @(negedge clock);
      clear = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clock);
         #1 seen |= rsp_valid;
      end
      chk("midrst_no_rsp", seen, 0);

      // Back-pressure on a SUB result, then same-edge retire + accept.
      issue(4'd3, 32'd9, 32'd4);
      wait_rsp(lat);
      chk("bp_lat", lat, 1);
      @(negedge clock);
      req_valid = 1'b1;
      req_op = 4'd0;
      req_a = 32'hF0;
      req_b = 32'h3C;
      repeat (5) begin
         @(posedge clock);
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_lo", rsp_lo, 5);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_cntrl_held", alu_cntrl, 3);
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      #1;
      chk("b2b_req_ready", req_ready, 1);
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("b2b_cntrl", alu_cntrl, 0);
      chk("b2b_alu_a", alu_a, 32'hF0);
      chk("b2b_valid_drop", rsp_valid, 0);
      wait_rsp(lat);
      chk("b2b_lat", lat, 1);
      chk("b2b_lo", rsp_lo, 32'h30);
      chk("b2b_hi", rsp_hi, 0);
      retire();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
